// File: rtl/vote_machine_param.sv
`default_nettype none
// ============================================================================
// Module  : vote_machine_param
// Brief   : Parametrised N-candidate voting core with debounce, armed ballots,
//           saturating tallies and registered leader/tie tracking.
// Rev     : 1.0  initial release
// ============================================================================
module vote_machine_param #(
   parameter int NUM_CAND = 4,
   parameter int CNT_W    = 8,
   parameter int DEBOUNCE = 10,
   parameter int ACK_HOLD = 10
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        mode,
   input  logic                        arm,
   input  logic [NUM_CAND-1:0]         button,
   output logic [CNT_W-1:0]            led,
   output logic                        ready,
   output logic                        spoiled,
   output logic [$clog2(NUM_CAND)-1:0] leader,
   output logic                        tie,
   output logic [NUM_CAND-1:0]         sat
);

   localparam int IDX_W  = $clog2(NUM_CAND);
   localparam int DB_W   = $clog2(DEBOUNCE + 2);
   localparam int HOLD_W = $clog2(ACK_HOLD + 1);

   localparam logic [CNT_W-1:0] C_MAX      = '1;
   localparam logic [CNT_W-1:0] C_NEAR_MAX = {{(CNT_W-1){1'b1}}, 1'b0};

   localparam logic [1:0] S_LOCKED = 2'd0;
   localparam logic [1:0] S_READY  = 2'd1;
   localparam logic [1:0] S_ACK    = 2'd2;

   logic [1:0]          r_state;
   logic [1:0]          w_next_state;
   logic [HOLD_W-1:0]   r_hold;
   logic [DB_W-1:0]     r_db_cnt [NUM_CAND];
   logic [CNT_W-1:0]    r_tally  [NUM_CAND];
   logic [NUM_CAND-1:0] w_valid;
   logic [NUM_CAND-1:0] r_sat;
   logic [CNT_W-1:0]    r_disp;
   logic [IDX_W-1:0]    w_sel;
   logic [IDX_W-1:0]    w_lead;
   logic [IDX_W-1:0]    r_leader;
   logic [CNT_W-1:0]    w_max;
   logic                w_tie;
   logic                r_tie;
   logic                r_spoiled;
   logic                w_any_valid;
   logic                w_one_valid;
   logic                w_accept;
   logic                w_spoil;
   logic                w_ack;

   // Counter parks at DEBOUNCE+1 while held, so a held button fires only once.
   for (genvar g = 0; g < NUM_CAND; g++) begin : g_debounce
      always_ff @(posedge clock) begin
         if (!reset_n)
            r_db_cnt[g] <= '0;
         else if (!button[g])
            r_db_cnt[g] <= '0;
         else if (r_db_cnt[g] <= DB_W'(DEBOUNCE))
            r_db_cnt[g] <= r_db_cnt[g] + DB_W'(1);
      end
      assign w_valid[g] = (r_db_cnt[g] == DB_W'(DEBOUNCE));
   end

   assign w_any_valid = |w_valid;
   assign w_one_valid = w_any_valid && ((w_valid & (w_valid - NUM_CAND'(1))) == '0);

   always_comb begin
      w_sel = '0;
      for (int i = NUM_CAND - 1; i >= 0; i--)
         if (w_valid[i]) w_sel = IDX_W'(i);
   end

   assign w_accept = (r_state == S_READY) && !mode && w_one_valid;
   assign w_spoil  = (r_state == S_READY) && !mode && w_any_valid && !w_one_valid;

   always_ff @(posedge clock) begin
      if (!reset_n)
         r_state <= S_LOCKED;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_LOCKED: if (arm && !mode) w_next_state = S_READY;
         S_READY: begin
            if (mode)             w_next_state = S_LOCKED;
            else if (w_one_valid) w_next_state = S_ACK;
            else if (w_any_valid) w_next_state = S_LOCKED;
         end
         S_ACK:    if (r_hold == HOLD_W'(1)) w_next_state = S_LOCKED;
         default:  w_next_state = S_LOCKED;
      endcase
   end

   always_comb begin
      ready = (r_state == S_READY);
      w_ack = (r_state == S_ACK);
   end

   always_ff @(posedge clock) begin
      if (!reset_n)
         r_hold <= '0;
      else if (w_accept)
         r_hold <= HOLD_W'(ACK_HOLD);
      else if (w_ack && r_hold != '0)
         r_hold <= r_hold - HOLD_W'(1);
   end

   always_ff @(posedge clock) begin
      if (!reset_n)
         r_spoiled <= 1'b0;
      else
         r_spoiled <= w_spoil;
   end

   // A vote at max is still accepted; only the increment is suppressed.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
         r_sat <= '0;
      end else begin
         for (int i = 0; i < NUM_CAND; i++) begin
            if (w_accept && w_valid[i] && r_tally[i] != C_MAX) begin
               r_tally[i] <= r_tally[i] + CNT_W'(1);
               if (r_tally[i] == C_NEAR_MAX) r_sat[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n)
         r_disp <= '0;
      else if (!mode)
         r_disp <= '0;
      else if (w_any_valid)
         r_disp <= r_tally[w_sel];
   end

   always_comb begin
      w_max  = '0;
      w_lead = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (r_tally[i] > w_max) begin
            w_max  = r_tally[i];
            w_lead = IDX_W'(i);
         end
      end
   end

   always_comb begin
      int n_eq;
      n_eq = 0;
      for (int i = 0; i < NUM_CAND; i++)
         if (r_tally[i] == w_max) n_eq = n_eq + 1;
      w_tie = (n_eq >= 2);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_leader <= '0;
         r_tie    <= 1'b1;
      end else begin
         r_leader <= w_lead;
         r_tie    <= w_tie;
      end
   end

   assign led     = mode ? r_disp : (w_ack ? C_MAX : '0);
   assign spoiled = r_spoiled;
   assign leader  = r_leader;
   assign tie     = r_tie;
   assign sat     = r_sat;

endmodule
`default_nettype wire

// File: doc/vote_machine_param.md
Name: vote_machine_param

Overview:
- Parametrised successor to the fixed 4-candidate voting machine. It supports N candidates, configurable debounce and acknowledge lengths, and saturating tallies.
- A ballot FSM accepts one vote per arm, spoils simultaneous presses, and tracks the leader and ties.
- It sits between the debounced-free push buttons/mode switch and the LED display. It is the top-level voting core.

Parameters:
- NUM_CAND, 4, number of candidates/buttons (2..16).
- CNT_W, 8, tally width per candidate; also the led width.
- DEBOUNCE, 10, consecutive high cycles before a press is valid (>=1).
- ACK_HOLD, 10, cycles the led shows all-ones after an accepted vote.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- mode  in  1  0 = voting, 1 = result display.
- arm  in  1  single-cycle pulse from the official that enables the next ballot.
- button  in  NUM_CAND  raw candidate buttons, bit i = candidate i.
- led  out  CNT_W  display bus.
- ready  out  1  a ballot is armed and accepting.
- spoiled  out  1  one-cycle pulse when a ballot is rejected.
- leader  out  $clog2(NUM_CAND)  index of the highest tally.
- tie  out  1  the leader tally is shared with at least one other candidate.
- sat  out  NUM_CAND  bit i = tally i saturated.

Behaviour:
- Reset (reset_n=0 at a clock edge): all tallies 0, debounce counters 0, FSM to LOCKED, led=0, ready=0, spoiled=0, leader=0, tie=1, sat=0. Reset mid-ballot or mid-ack aborts with no tally change.
- Debounce, per bit:
  - Counter increments while button[i]=1 and counter<=DEBOUNCE.
  - Counter clears when button[i]=0.
  - valid[i] is a one-cycle pulse on the cycle the counter equals DEBOUNCE, i.e. DEBOUNCE+1 edges after the press is sampled.
  - Holding the button produces no further pulse; the button must be released to re-fire.
- FSM, states LOCKED, READY, ACK:
  - LOCKED: ready=0. On arm=1 with mode=0, go to READY. arm in mode=1 is ignored.
  - READY: ready=1.
    - Exactly one valid[i]: tally[i] += 1 (saturating), go to ACK, load the hold counter with ACK_HOLD.
    - Two or more valid bits in the same cycle: no tally change, spoiled=1 for one cycle, go to LOCKED.
    - mode=1: go to LOCKED, ballot forfeited.
  - ACK: led=all-ones. The hold counter decrements each cycle; at 1, go to LOCKED next cycle. Duration is exactly ACK_HOLD cycles. Valid pulses are ignored.
- arm in READY or ACK is ignored; there is no queuing.
- The tally increments on the edge after the valid pulse. ready drops in the same cycle the tally updates.
- Saturation: a tally stays at 2^CNT_W-1. sat[i] is set once the tally reaches the max and cleared only by reset. An increment at max is a no-op but still counts as an accepted ballot (ACK entered).
- led in mode=0: all-ones in ACK, otherwise 0.
- led in mode=1:
  - On a valid[i] pulse, led <= tally[i] and is held until another valid or a mode change.
  - Simultaneous valids select the lowest index.
  - On entering mode=1, led=0 until the first press.
- Leader/tie:
  - Registered, updated the cycle after any tally change (1-cycle latency).
  - leader = lowest index holding the maximum tally.
  - tie=1 if at least two tallies equal the maximum; all-zero tallies give tie=1.
- Valid pulses arriving in LOCKED are discarded silently (no spoiled).

Test Plan:
- Reset, arm, hold button[2] for 11 cycles -> tally2=1, led=FF for exactly 10 cycles, leader=2, tie=0, ready low after the vote.
- No arm, press button[0] 20 cycles -> no tally change, spoiled=0, led stays 0.
- Arm, buttons 1 and 3 rise in the same cycle and held -> spoiled pulses once, all tallies unchanged, FSM LOCKED.
- Arm, button[0] pulses 9 high cycles then released -> no vote. A 10-cycle hold -> vote counted. Continued holding -> no second vote even after re-arm until released.
- CNT_W=4: 16 armed votes for candidate 1 -> tally1=15, sat[1]=1, ACK still asserted on the 16th.
- Votes cand0=2, cand3=2, then mode=1 and press button[3] -> led=2, leader=0, tie=1. Assert reset_n=0 during an ACK -> all cleared next edge.
